jt12_acc_seq: RTL
=================

// Module: jt12_acc_seq
// PURPOSE
//   Slot sequencer and per-channel configuration store feeding the channel accumulator.
//   Walks the 24 operator slots of one sample (6 channels x 4 operators).
//   Per slot it drives zero, s1..s4_enters, ch6op, alg, rl and pcm_en to the accumulator.
//   Host-side register writes are shadowed and take effect only at a sample boundary,
//   so no sample mixes old and new settings.
// PARAMETERS
//   NCH    6        channels sequenced; fixed at 6, other values unsupported
//   RL_RST 2'b11    reset value of every channel's rl (both outputs enabled)
// PORTS
//   rst        in   1  synchronous reset, active high
//   clk        in   1  clock
//   clk_en     in   1  advance enable; all state changes only when high
//   cfg_we     in   1  write strobe for channel alg/rl, sampled on clk_en
//   cfg_ch     in   3  target channel 0..5; 6 and 7 ignored
//   cfg_alg    in   3  algorithm to store
//   cfg_rl     in   2  {left,right} enables to store
//   cfg_pcm_we in   1  write strobe for pcm_en, sampled on clk_en
//   cfg_pcm    in   1  pcm_en value (channel 6 only)
//   zero       out  1  high during slot 0 = first slot of a new sample
//   s1_enters  out  1  operator S1 slot
//   s2_enters  out  1  operator S2 slot
//   s3_enters  out  1  operator S3 slot
//   s4_enters  out  1  operator S4 slot
//   ch6op      out  1  current slot belongs to channel index 5
//   cur_ch     out  3  current channel 0..5
//   alg        out  3  live algorithm of cur_ch
//   rl         out  2  live {left,right} enables of cur_ch
//   pcm_en     out  1  live pcm enable
// BEHAVIOUR
//   - Internal slot counter cnt: 0..23, +1 per clk_en, wraps 23->0; reset to 0.
//   - Slot map: grp=cnt/6, ch=cnt%6; grp 0:S1, 1:S3, 2:S2, 3:S4 (hardware order).
//   - All outputs are registered, loaded on clk_en from current cnt.
//     Outputs show slot k in the cycle after the clk_en at which cnt==k; no other latency.
//   - Exactly one sN_enters high per valid output slot; zero high iff slot 0.
//   - Reset values: all outputs 0 except rl=RL_RST.
//     Pending and live tables: alg=0, rl=RL_RST, pcm_en=0.
//   - Tables: pending[6] written by cfg_we (cfg_ch<6 only); pcm_pend written by cfg_pcm_we.
//     Writes with cfg_ch 6/7 are dropped with no side effect.
//   - Commit at clk_en with cnt==0: live<=pending, pcm_live<=pcm_pend.
//     Slot-0 outputs use the newly committed values.
//   - A write on the commit clk_en updates pending only; it goes live at the next boundary.
//   - Repeated writes to one channel within a sample: last write wins.
//   - clk_en low: state and outputs hold.
//   - rst mid-sample: cnt->0, tables and outputs to reset values; next clk_en emits slot 0.
// CONFIGURATION
//   JT12_ACC_SEQ_MUTE_EN defined:
//     - adds ports mute_we(in,1) and mute_mask(in,6).
//     - mask is shadowed and committed with the tables.
//     - bit n set forces rl=2'b00 on channel n slots.
//     - reset mask 0.
//   JT12_ACC_SEQ_MUTE_EN undefined:
//     - no mute ports.
//     - rl always the live table value.
// TESTING
//   1. rst, then 48 clk_en -> zero high on output slots 0 and 24 only.
//      s1 on slots 0-5, s3 on 6-11, s2 on 12-17, s4 on 18-23.
//   2. ch6op high on slots 5,11,17,23; cur_ch cycles 0..5 four times per sample.
//   3. cfg_we ch=2 alg=7 rl=01 at cnt=10 -> slots 14,20 still alg=0 rl=11.
//      Next sample slots 2,8,14,20 show alg=7 rl=01.
//   4. Commit-cycle write: cfg_we ch=0 alg=5 on the clk_en with cnt==0.
//      -> not live this sample; live from the following sample.
//   5. cfg_we cfg_ch=6 alg=3; cfg_pcm_we=1 -> no table change; pcm_en=1 from next slot 0.
//   6. rst asserted at cnt=13 -> outputs reset values; first clk_en after -> slot 0, zero=1.
//      With JT12_ACC_SEQ_MUTE_EN: mask=6'b000010 -> rl=00 on channel-1 slots from next sample.

Source files
------------

// File: rtl/jt12_acc_seq_if.sv
// Bus bundle for jt12_acc_seq: host configuration inputs and per-slot accumulator controls.
// Optional mute ports appear only when JT12_ACC_SEQ_MUTE_EN is defined.
interface jt12_acc_seq_if;
  // No handshake: clk_en qualifies every transfer, cfg strobes are single-cycle
  // requests sampled on clk_en, and slot outputs are valid the cycle after each clk_en.
  logic       clk_en;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_alg;
  logic [1:0] cfg_rl;
  logic       cfg_pcm_we;
  logic       cfg_pcm;
`ifdef JT12_ACC_SEQ_MUTE_EN
  logic       mute_we;
  logic [5:0] mute_mask;
`endif
  logic       zero;
  logic       s1_enters;
  logic       s2_enters;
  logic       s3_enters;
  logic       s4_enters;
  logic       ch6op;
  logic [2:0] cur_ch;
  logic [2:0] alg;
  logic [1:0] rl;
  logic       pcm_en;

  modport master (
    output clk_en, cfg_we, cfg_ch, cfg_alg, cfg_rl, cfg_pcm_we, cfg_pcm,
`ifdef JT12_ACC_SEQ_MUTE_EN
    output mute_we, mute_mask,
`endif
    input  zero, s1_enters, s2_enters, s3_enters, s4_enters, ch6op,
    input  cur_ch, alg, rl, pcm_en
  );

  modport slave (
    input  clk_en, cfg_we, cfg_ch, cfg_alg, cfg_rl, cfg_pcm_we, cfg_pcm,
`ifdef JT12_ACC_SEQ_MUTE_EN
    input  mute_we, mute_mask,
`endif
    output zero, s1_enters, s2_enters, s3_enters, s4_enters, ch6op,
    output cur_ch, alg, rl, pcm_en
  );
endinterface

// File: rtl/jt12_acc_seq.sv
// Slot sequencer for 6 channels x 4 operators with sample-boundary shadowed channel config.
// Optional per-channel mute mask enabled by defining JT12_ACC_SEQ_MUTE_EN.
module jt12_acc_seq #(
  parameter int         NCH    = 6,
  parameter logic [1:0] RL_RST = 2'b11
) (
  input  logic          rst,
  input  logic          clk,
  jt12_acc_seq_if.slave bus
);
  localparam logic [2:0] NCH_L = 3'(NCH);

  logic [4:0] cnt;
  logic [1:0] grp;
  logic [2:0] slot_ch;
  logic [2:0] pend_alg [NCH];
  logic [1:0] pend_rl  [NCH];
  logic [2:0] live_alg [NCH];
  logic [1:0] live_rl  [NCH];
  logic       pcm_pend, pcm_live;
  logic [2:0] sel_alg;
  logic [1:0] sel_rl;
  logic       sel_pcm;
`ifdef JT12_ACC_SEQ_MUTE_EN
  logic [5:0] pend_mask, live_mask;
`endif

  always_comb begin
    grp     = 2'd0;
    slot_ch = cnt[2:0];
    if (cnt >= 5'd18) begin
      grp     = 2'd3;
      slot_ch = 3'(cnt - 5'd18);
    end else if (cnt >= 5'd12) begin
      grp     = 2'd2;
      slot_ch = 3'(cnt - 5'd12);
    end else if (cnt >= 5'd6) begin
      grp     = 2'd1;
      slot_ch = 3'(cnt - 5'd6);
    end
  end

  // Slot 0 is the commit slot, so its outputs bypass to the values being committed.
  always_comb begin
    sel_alg = live_alg[slot_ch];
    sel_rl  = live_rl[slot_ch];
    sel_pcm = pcm_live;
    if (cnt == 5'd0) begin
      sel_alg = pend_alg[slot_ch];
      sel_rl  = pend_rl[slot_ch];
      sel_pcm = pcm_pend;
`ifdef JT12_ACC_SEQ_MUTE_EN
      if (pend_mask[slot_ch]) sel_rl = 2'b00;
    end else if (live_mask[slot_ch]) begin
      sel_rl = 2'b00;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 5'd0;
      pcm_pend      <= 1'b0;
      pcm_live      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend_alg[i] <= 3'd0;
        pend_rl[i]  <= RL_RST;
        live_alg[i] <= 3'd0;
        live_rl[i]  <= RL_RST;
      end
`ifdef JT12_ACC_SEQ_MUTE_EN
      pend_mask     <= 6'd0;
      live_mask     <= 6'd0;
`endif
      bus.zero      <= 1'b0;
      bus.s1_enters <= 1'b0;
      bus.s2_enters <= 1'b0;
      bus.s3_enters <= 1'b0;
      bus.s4_enters <= 1'b0;
      bus.ch6op     <= 1'b0;
      bus.cur_ch    <= 3'd0;
      bus.alg       <= 3'd0;
      bus.rl        <= RL_RST;
      bus.pcm_en    <= 1'b0;
    end else if (bus.clk_en) begin
      cnt <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
      if (cnt == 5'd0) begin
        for (int i = 0; i < NCH; i++) begin
          live_alg[i] <= pend_alg[i];
          live_rl[i]  <= pend_rl[i];
        end
        pcm_live  <= pcm_pend;
`ifdef JT12_ACC_SEQ_MUTE_EN
        live_mask <= pend_mask;
`endif
      end
      // Pending writes land after the commit read above (non-blocking), so a
      // write on the commit cycle waits for the next boundary.
      if (bus.cfg_we && bus.cfg_ch < NCH_L) begin
        pend_alg[bus.cfg_ch] <= bus.cfg_alg;
        pend_rl[bus.cfg_ch]  <= bus.cfg_rl;
      end
      if (bus.cfg_pcm_we) pcm_pend <= bus.cfg_pcm;
`ifdef JT12_ACC_SEQ_MUTE_EN
      if (bus.mute_we) pend_mask <= bus.mute_mask;
`endif
      bus.zero      <= (cnt == 5'd0);
      bus.s1_enters <= (grp == 2'd0);
      bus.s3_enters <= (grp == 2'd1);
      bus.s2_enters <= (grp == 2'd2);
      bus.s4_enters <= (grp == 2'd3);
      bus.ch6op     <= (slot_ch == 3'd5);
      bus.cur_ch    <= slot_ch;
      bus.alg       <= sel_alg;
      bus.rl        <= sel_rl;
      bus.pcm_en    <= sel_pcm;
    end
  end
endmodule
